gpio_out_arbiter: RTL
=====================

Name: gpio_out_arbiter

Overview:
- Shares the GPIO output-data and output-enable registers between NumReq hardware requesters and the software register path.
- Each requester issues masked-write transactions. Typical requesters are a PWM engine, a bit-bang SPI engine and a DMA-driven pattern generator.
- The block arbitrates round-robin, with software always taking priority, and applies masked read-modify-write to the internal out/oe state.
- Its outputs drive the GPIO pads directly.

Parameters:
- NumReq, 4, number of hardware requesters (>= 2; need not be a power of two).
- Width, 32, GPIO pin count.
- IdW, $clog2(NumReq), width of the grant index (localparam).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- req_valid_i  in  NumReq  per-requester request valid.
- req_ready_o  out  NumReq  per-requester accept; at most one bit high per cycle.
- req_oe_sel_i  in  NumReq  per-requester target select: 0 = output data, 1 = output enable.
- req_mask_i  in  NumReq*Width  per-requester bit mask; requester k occupies [k*Width +: Width].
- req_data_i  in  NumReq*Width  per-requester write data, same packing as req_mask_i.
- sw_we_i  in  1  software full-register write strobe, from register-file qe.
- sw_oe_sel_i  in  1  software target: 0 = data, 1 = oe.
- sw_data_i  in  Width  software write value.
- cio_gpio_o  out  Width  pad output data.
- cio_gpio_en_o  out  Width  pad output enable.
- grant_valid_o  out  1  registered pulse: a request was applied last cycle.
- grant_id_o  out  IdW  index of the requester applied last cycle.

Interface (already decided):
- One clock, clk_i.
- Reset rst_ni is asynchronous and active-low.

Behaviour:
- Reset values: cio_gpio_o = 0, cio_gpio_en_o = 0, grant_valid_o = 0, grant_id_o = 0, round-robin pointer rr_q = 0.
- req_ready_o = 0 while rst_ni is low and in the first cycle after deassertion, because it is gated by a registered init flag.

Arbitration (combinational, each cycle):
- If sw_we_i = 1, all req_ready_o = 0.
- Otherwise the winner is the first k with req_valid_i[k] = 1, scanning rr_q, rr_q+1, ..., wrapping from NumReq-1 to 0.
- req_ready_o[winner] = 1. Ready may depend on valid.

Handshake:
- A transfer occurs on valid & ready.
- A requester holds valid and its payload stable until ready; dropping valid before ready is a protocol violation (asserted in simulation).

Update on the clock edge after a transfer:
- The target register is out_q or oe_q, chosen by req_oe_sel_i.
- target <= (target & ~mask) | (data & mask).
- rr_q <= (winner == NumReq-1) ? 0 : winner+1.
- grant_valid_o <= 1 and grant_id_o <= winner.

Software write:
- When sw_we_i = 1, the selected register <= sw_data_i (full overwrite).
- rr_q is unchanged, and grant_valid_o <= 0 for that cycle.

Latency: a transfer or software write in cycle N is visible on cio_gpio_o / cio_gpio_en_o in cycle N+1.

Idle: with no transfer, grant_valid_o <= 0 and grant_id_o holds its value.

Boundary conditions:
- mask = 0: still accepted, registers unchanged, rr_q advances, grant_valid_o still pulses.
- Only one transfer per cycle, so data and oe are never updated by two hardware requesters in the same cycle.
- Fairness: with sw_we_i low, any continuously valid requester is granted within NumReq cycles.
- Software priority can starve hardware requesters; this is intended.
- Async reset mid-transaction: all state clears immediately and un-accepted requests are not remembered; requesters re-present after reset.

Optional Feature:
Macro: GPIO_ARB_CONFLICT_EN.
- Defined:
  - Adds output port conflict_o (1 bit, registered, reset 0).
  - conflict_o pulses one cycle after any cycle in which two or more valid requesters with the same oe_sel have overlapping masks (bitwise AND non-zero).
  - Detection is independent of the grant, and also fires while sw_we_i = 1.
- Not defined: port and logic absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rst_ni = 0 with req_valid_i = 4'hF -> all outputs 0 and req_ready_o = 0. The first grant goes to requester 0 in the second cycle after release.
2. Masked write: out_q = 32'hFFFF_0000; requester 2 sends mask = 32'h0000_FFFF, data = 32'h0000_1234, oe_sel = 0 -> next cycle cio_gpio_o = 32'hFFFF_1234, grant_valid_o = 1, grant_id_o = 2.
3. Round-robin: all four requesters valid continuously -> grant order 0, 1, 2, 3, 0, each req_ready_o high exactly once in every 4 consecutive cycles.
4. Software priority: sw_we_i = 1 with sw_oe_sel_i = 1, sw_data_i = 32'h0000_00FF, while requester 1 is valid -> req_ready_o = 0; next cycle cio_gpio_en_o = 32'h0000_00FF; requester 1 is granted the following cycle.
5. Wrap and empty mask: rr_q = 3, only requester 3 valid with mask = 0 -> registers unchanged, grant_id_o = 3, next winner search starts at 0.
6. With GPIO_ARB_CONFLICT_EN defined: requesters 0 and 1 valid, both oe_sel = 0, masks 32'h0000_0003 and 32'h0000_0002 -> conflict_o = 1 one cycle later; with masks 32'h1 and 32'h2 -> conflict_o stays 0.

Source files
------------

// File: rtl/gpio_out_arbiter.sv
// Purpose: round-robin arbiter that applies masked writes from NumReq requesters plus software to the GPIO out/oe registers.
// Latency: a transfer or software write in cycle N drives the pads in cycle N+1; grant_valid_o/grant_id_o report it in N+1.
// Backpressure: at most one req_ready_o per cycle, all low during a software write and in the first cycle after reset.
// Optional build macro GPIO_ARB_CONFLICT_EN adds conflict_o (overlapping-mask detector across valid requesters).
module gpio_out_arbiter #(
  parameter int NumReq = 4,
  parameter int Width  = 32,
  localparam int IdW   = $clog2(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq-1:0]       req_oe_sel_i,
  input  logic [NumReq*Width-1:0] req_mask_i,
  input  logic [NumReq*Width-1:0] req_data_i,
  input  logic                    sw_we_i,
  input  logic                    sw_oe_sel_i,
  input  logic [Width-1:0]        sw_data_i,
  output logic [Width-1:0]        cio_gpio_o,
  output logic [Width-1:0]        cio_gpio_en_o,
  output logic                    grant_valid_o,
  output logic [IdW-1:0]          grant_id_o
`ifdef GPIO_ARB_CONFLICT_EN
  ,
  output logic                    conflict_o
`endif
);

  logic             init_q;
  logic [IdW-1:0]   rr_q;
  logic [Width-1:0] out_q;
  logic [Width-1:0] oe_q;
  logic             grant_valid_q;
  logic [IdW-1:0]   grant_id_q;

  logic             found;
  logic [IdW-1:0]   winner;
  logic [IdW-1:0]   idx;
  int               cand;
  logic             grant_en;
  logic [IdW-1:0]   rr_next;
  logic [Width-1:0] sel_mask;
  logic [Width-1:0] sel_data;
  logic             sel_oe;

  // Holds ready low until one full cycle after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  // Round-robin search: first valid requester starting at rr_q, wrapping at NumReq-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    idx    = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NumReq) begin
        cand = cand - NumReq;
      end
      idx = IdW'(cand);
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Software writes pre-empt every hardware requester for the cycle.
  assign grant_en = init_q & ~sw_we_i & found;
  assign rr_next  = (winner == IdW'(NumReq - 1)) ? '0 : winner + 1'b1;

  // One-hot ready to the winner only.
  always_comb begin
    req_ready_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      req_ready_o[k] = grant_en && (winner == IdW'(k));
    end
  end

  // Select the winning requester's payload.
  always_comb begin
    sel_mask = '0;
    sel_data = '0;
    sel_oe   = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      if (winner == IdW'(k)) begin
        sel_mask = req_mask_i[k*Width +: Width];
        sel_data = req_data_i[k*Width +: Width];
        sel_oe   = req_oe_sel_i[k];
      end
    end
  end

  // Register update: software full overwrite wins, otherwise masked read-modify-write of the granted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q         <= '0;
      oe_q          <= '0;
      rr_q          <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
    end else if (sw_we_i) begin
      if (sw_oe_sel_i) begin
        oe_q <= sw_data_i;
      end else begin
        out_q <= sw_data_i;
      end
      grant_valid_q <= 1'b0;
    end else if (grant_en) begin
      if (sel_oe) begin
        oe_q <= (oe_q & ~sel_mask) | (sel_data & sel_mask);
      end else begin
        out_q <= (out_q & ~sel_mask) | (sel_data & sel_mask);
      end
      rr_q          <= rr_next;
      grant_valid_q <= 1'b1;
      grant_id_q    <= winner;
    end else begin
      grant_valid_q <= 1'b0;
    end
  end

  assign cio_gpio_o    = out_q;
  assign cio_gpio_en_o = oe_q;
  assign grant_valid_o = grant_valid_q;
  assign grant_id_o    = grant_id_q;

`ifdef GPIO_ARB_CONFLICT_EN
  logic conflict_d;
  logic conflict_q;

  // Any two valid requesters aiming at the same register with overlapping masks, regardless of grant.
  always_comb begin
    conflict_d = 1'b0;
    for (int j = 0; j < NumReq; j++) begin
      for (int k = j + 1; k < NumReq; k++) begin
        if (req_valid_i[j] && req_valid_i[k] && (req_oe_sel_i[j] == req_oe_sel_i[k]) &&
            |(req_mask_i[j*Width +: Width] & req_mask_i[k*Width +: Width])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  // Registered one-cycle conflict pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_o = conflict_q;
`endif

  // A requester must keep valid asserted until it is accepted.
  for (genvar g = 0; g < NumReq; g++) begin : g_hold_chk
    a_valid_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[g] && !req_ready_o[g]) |=> req_valid_i[g]);
  end

endmodule
